// File: rtl/quad_decoder_pkg.sv
// quad_decoder_pkg: FSM states, phase constants and the A/B step decoder shared by the quadrature decoder.
package quad_decoder_pkg;
  typedef enum logic {INIT, TRACK} state_t;
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;
  typedef struct packed {
    logic valid;
    logic up;
    logic illegal;
  } step_t;
  // Phases are {A,B}; the up direction walks 00->10->11->01->00.
  function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
    step_t r;
    logic [1:0] nxt_up;
    nxt_up = prev == PH_00 ? PH_10 : prev == PH_10 ? PH_11 : prev == PH_11 ? PH_01 : PH_00;
    r.valid = (prev ^ cur) == 2'b01 || (prev ^ cur) == 2'b10;
    r.up = cur == nxt_up;
    r.illegal = (prev ^ cur) == 2'b11;
    return r;
  endfunction
endpackage

// File: rtl/quad_decoder_if.sv
// quad_decoder_if: encoder pins, controls and position outputs of the quadrature decoder.
interface quad_decoder_if #(parameter int WIDTH = 16);
  logic a_in;
  logic b_in;
  logic en;
  logic clr;
  logic [WIDTH-1:0] count;
  logic dir;
  logic step;
  logic err;
  logic err_flag;
  modport master(output a_in, b_in, en, clr, input count, dir, step, err, err_flag);
  modport slave(input a_in, b_in, en, clr, output count, dir, step, err, err_flag);
endinterface

// File: rtl/quad_decoder_filter.sv
// quad_decoder_filter: 2-flop synchroniser plus glitch filter for one encoder phase.
module quad_decoder_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic settled
);
  // settled once the synchroniser is full and FILTER_LEN samples have been judged
  localparam int SETTLE = FILTER_LEN + 2;
  localparam int CW = $clog2(SETTLE + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic [CW-1:0] scnt;
  assign settled = scnt == CW'(SETTLE);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
      q <= 1'b0;
      cnt <= '0;
      scnt <= '0;
    end else begin
      sync <= {sync[0], d};
      scnt <= settled ? scnt : scnt + 1'b1;
      if (sync[1] == q) cnt <= '0;
      else if (cnt == CW'(FILTER_LEN - 1)) begin
        q <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: x4 quadrature decoder with filtered inputs, INIT/TRACK FSM and up/down position counter.
module quad_decoder
  import quad_decoder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FILTER_LEN = 3
) (
  input logic clk,
  input logic rst,
  quad_decoder_if.slave bus
);
  logic fa, fb, sa, sb;
  logic [1:0] prev, cur;
  state_t state, state_d;
  step_t ds;
  logic [WIDTH-1:0] count, count_d;
  logic dir, dir_d, step, step_d, err, err_d, flag, flag_d, mv, track;
  quad_decoder_filter #(.FILTER_LEN(FILTER_LEN)) u_a (.clk(clk), .rst(rst), .d(bus.a_in), .q(fa), .settled(sa));
  quad_decoder_filter #(.FILTER_LEN(FILTER_LEN)) u_b (.clk(clk), .rst(rst), .d(bus.b_in), .q(fb), .settled(sb));
  assign cur = {fa, fb};
  assign ds = decode_step(prev, cur);
  assign track = state == TRACK;
  // prev follows cur every cycle, so the last INIT load is the settled phase
  always_comb begin
    state_d = (!track && sa && sb) ? TRACK : state;
    mv = track && ds.valid;
    dir_d = mv ? ds.up : dir;
    step_d = mv && bus.en && !bus.clr;
    err_d = track && ds.illegal;
    flag_d = !bus.clr && (flag || err_d);
    count_d = bus.clr ? '0 : step_d ? (ds.up ? count + 1'b1 : count - 1'b1) : count;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= INIT;
      prev <= '0;
      count <= '0;
      dir <= 1'b0;
      step <= 1'b0;
      err <= 1'b0;
      flag <= 1'b0;
    end else begin
      state <= state_d;
      prev <= cur;
      count <= count_d;
      dir <= dir_d;
      step <= step_d;
      err <= err_d;
      flag <= flag_d;
    end
  end
  assign bus.count = count;
  assign bus.dir = dir;
  assign bus.step = step;
  assign bus.err = err;
  assign bus.err_flag = flag;
endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: table-driven, hand-written and random checks of quad_decoder against a pin-history model.
module tb_quad_decoder;
  localparam int FL = 3;
  logic clk = 1'b0, rst = 1'b1, a = 1'b0, b = 1'b0, en = 1'b1, clr = 1'b0;
  always #5 clk = ~clk;
  quad_decoder_if #(.WIDTH(16)) if16();
  quad_decoder_if #(.WIDTH(4)) if4();
  assign if16.a_in = a;
  assign if16.b_in = b;
  assign if16.en = en;
  assign if16.clr = clr;
  assign if4.a_in = a;
  assign if4.b_in = b;
  assign if4.en = en;
  assign if4.clr = clr;
  quad_decoder #(.WIDTH(16), .FILTER_LEN(FL)) dut16 (.clk(clk), .rst(rst), .bus(if16));
  quad_decoder #(.WIDTH(4), .FILTER_LEN(FL)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  int vectors = 0, miscompares = 0, steps_seen = 0;
  int n, m_count;
  bit ha[$], hb[$];
  bit fa, fb, m_dir, m_step, m_err, m_flag;
  bit [1:0] pv;

  typedef struct {
    bit a, b, en, clr;
    int hold;
    int exp_count;
    bit exp_dir, exp_flag;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // position of a phase along the up sequence 00,10,11,01
  function automatic int pos(input bit [1:0] p);
    return p == 2'b00 ? 0 : p == 2'b10 ? 1 : p == 2'b11 ? 2 : 3;
  endfunction

  // value the filter judges at edge e: the pin level sampled two edges earlier
  function automatic bit seen(input bit q[$], input int e);
    return e >= 3 ? q[e-3] : 1'b0;
  endfunction

  // level flips only if the last FL judged samples all disagree with it
  function automatic bit filt_next(input bit q[$], input bit f, input int e);
    for (int j = 0; j < FL; j++) if (seen(q, e - j) == f) return f;
    return !f;
  endfunction

  task automatic model_reset();
    n = 0;
    ha.delete();
    hb.delete();
    fa = 0; fb = 0; pv = 0;
    m_count = 0; m_dir = 0; m_step = 0; m_err = 0; m_flag = 0;
  endtask

  task automatic model_edge();
    bit [1:0] cur;
    int d;
    n++;
    ha.push_back(a);
    hb.push_back(b);
    cur = {fa, fb};
    m_step = 0;
    m_err = 0;
    if (n > FL + 3) begin
      d = (pos(cur) - pos(pv) + 4) % 4;
      if (d == 2) begin
        m_err = 1;
        m_flag = 1;
      end else if (d != 0) begin
        m_dir = d == 1;
        if (en && !clr) begin
          m_step = 1;
          m_count = (m_count + (d == 1 ? 1 : -1)) & 32'hFFFF;
        end
      end
    end
    pv = cur;
    if (clr) begin
      m_count = 0;
      m_flag = 0;
    end
    fa = filt_next(ha, fa, n);
    fb = filt_next(hb, fb, n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) model_edge();
    chk("count16", 32'(if16.count), 32'(m_count[15:0]));
    chk("count4", 32'(if4.count), 32'(m_count[3:0]));
    chk("dir", 32'(if16.dir), 32'(m_dir));
    chk("step", 32'(if16.step), 32'(m_step));
    chk("step4", 32'(if4.step), 32'(m_step));
    chk("err", 32'(if16.err), 32'(m_err));
    chk("err_flag", 32'(if16.err_flag), 32'(m_flag));
    if (if16.step === 1'b1) steps_seen++;
  endtask

  task automatic hold(input int k);
    repeat (k) tick();
  endtask

  initial begin
    bit [1:0] up_seq[4];
    int s0, r, h;
    up_seq = '{2'b00, 2'b10, 2'b11, 2'b01};
    model_reset();
    #2 rst = 1'b0;
    hold(2);
    chk("reset_count", 32'(if16.count), 0);
    chk("reset_flag", 32'(if16.err_flag), 0);
    rst = 1'b1;

    tbl.push_back('{0, 0, 1, 0, 10, 0, 0, 0});
    tbl.push_back('{1, 0, 1, 0, 8, 1, 1, 0});
    tbl.push_back('{1, 1, 1, 0, 8, 2, 1, 0});
    tbl.push_back('{0, 1, 1, 0, 8, 3, 1, 0});
    tbl.push_back('{0, 0, 1, 0, 8, 4, 1, 0});
    tbl.push_back('{0, 0, 1, 1, 1, 0, 1, 0});
    tbl.push_back('{0, 0, 1, 0, 7, 0, 1, 0});
    tbl.push_back('{0, 1, 1, 0, 8, 65535, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 8, 0, 1, 0});
    tbl.push_back('{1, 0, 0, 0, 8, 0, 1, 0});
    tbl.push_back('{1, 1, 0, 0, 8, 0, 1, 0});
    tbl.push_back('{0, 1, 0, 0, 8, 0, 1, 0});
    tbl.push_back('{0, 0, 1, 0, 8, 1, 1, 0});
    tbl.push_back('{1, 1, 1, 0, 8, 1, 1, 1});
    tbl.push_back('{1, 1, 1, 1, 1, 0, 1, 0});
    tbl.push_back('{1, 1, 1, 0, 7, 0, 1, 0});
    tbl.push_back('{0, 1, 1, 0, 8, 1, 1, 0});
    tbl.push_back('{0, 0, 1, 0, 8, 2, 1, 0});
    foreach (tbl[i]) begin
      a = tbl[i].a; b = tbl[i].b; en = tbl[i].en; clr = tbl[i].clr;
      hold(tbl[i].hold);
      clr = 1'b0;
      chk("tbl_count", 32'(if16.count), 32'(tbl[i].exp_count));
      chk("tbl_count4", 32'(if4.count), 32'(tbl[i].exp_count & 15));
      chk("tbl_dir", 32'(if16.dir), 32'(tbl[i].exp_dir));
      chk("tbl_flag", 32'(if16.err_flag), 32'(tbl[i].exp_flag));
      if (i == 4) chk("four_steps", steps_seen, 4);
    end

    s0 = steps_seen;
    a = 1; hold(2); a = 0; hold(10);
    chk("glitch_count", 32'(if16.count), 2);
    chk("glitch_steps", steps_seen - s0, 0);
    a = 1; hold(3); a = 0; hold(2);
    tick();
    chk("edge6_step", 32'(if16.step), 1);
    chk("edge6_count", 32'(if16.count), 3);
    hold(12);
    chk("pulse_back_count", 32'(if16.count), 2);

    rst = 1'b0;
    model_reset();
    a = 1; b = 1;
    hold(2);
    rst = 1'b1;
    s0 = steps_seen;
    hold(12);
    chk("init11_count", 32'(if16.count), 0);
    chk("init11_steps", steps_seen - s0, 0);
    a = 0; hold(8);
    chk("init11_step", 32'(if16.count), 1);

    b = 0; hold(5);
    clr = 1; tick(); clr = 0;
    chk("clr_step_count", 32'(if16.count), 0);
    for (int i = 1; i <= 7; i++) begin
      {a, b} = up_seq[i % 4];
      hold(8);
    end
    chk("seq_count7", 32'(if16.count), 7);
    {a, b} = 2'b00;
    hold(3);
    #2 rst = 1'b0;
    #1 chk("async_rst_count", 32'(if16.count), 0);
    model_reset();
    hold(2);
    rst = 1'b1;
    hold(12);
    chk("reinit_count", 32'(if16.count), 0);

    repeat (200) begin
      r = $urandom_range(0, 9);
      h = $urandom_range(1, 10);
      en = $urandom_range(0, 3) != 0;
      if (r < 4) {a, b} = {~b, a};
      else if (r < 7) {a, b} = {b, ~a};
      else if (r == 7) {a, b} = {~a, ~b};
      else if (r == 9) begin
        a = ~a;
        hold($urandom_range(1, 4));
        a = ~a;
      end
      if ($urandom_range(0, 15) == 0) begin
        clr = 1;
        tick();
        clr = 0;
      end
      hold(h);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
